// File: rtl/ropuf_pkg.sv
// Shared types and default sizing for the ROPUF time base.
package ropuf_pkg;

    localparam int RO_GATE_W = 20;
    localparam int RO_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } ro_cnt_state_t;

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer for an asynchronous RO signal plus a history flop,
// producing a one-cycle strobe per synchronized rising edge.
module ro_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic ro_in,
    output logic edge_stb
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ro_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_stb = s2 & ~s3;

endmodule

// File: rtl/ro_edge_counter.sv
// Counts synchronized RO rising edges over a 2^GATE_W cycle gate window and
// hands the saturating count to the consumer over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | two cycles flushing synchronizer history, no counting
// GATE  | counting edge strobes for 2^GATE_W cycles
// DONE  | result captured / held until res_ready
module ro_edge_counter
    import ropuf_pkg::*;
#(
    parameter int GATE_W = RO_GATE_W,
    parameter int CNT_W  = RO_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ro_in,
    input  logic             start,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_ovf
);

    ro_cnt_state_t     state;
    ro_cnt_state_t     state_nxt;
    logic              arm_cnt;
    logic [GATE_W-1:0] timer;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              edge_stb;
    logic              start_acc;
    logic              capture;
    logic              accept;

    ro_sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .ro_in    (ro_in),
        .edge_stb (edge_stb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        capture   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (arm_cnt) state_nxt = GATE;
            end
            GATE: begin
                if (&timer) state_nxt = DONE;
            end
            DONE: begin
                // First DONE cycle captures the final count; handshake only after that.
                if (!res_valid) begin
                    capture = 1'b1;
                end else if (res_ready) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_cnt <= 1'b0;
            timer   <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else begin
            arm_cnt <= (state == ARM) ? ~arm_cnt : 1'b0;
            timer   <= (state == GATE) ? timer + 1'b1 : '0;
            if (start_acc) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if ((state == GATE) && edge_stb) begin
                if (&cnt) ovf <= 1'b1;
                else      cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_count <= cnt;
            res_ovf   <= ovf;
        end else if (accept) begin
            res_valid <= 1'b0;
        end
    end

endmodule
